// File: rtl/uart_bus_ctrl_if.sv
// Signal bundle between uart_bus_ctrl, the UART register port, TX requesters and the RX consumer.
// master = controller view, slave = environment (UART, requesters, consumer) view.
interface uart_bus_ctrl_if;
    logic       u_cs;
    logic       u_rnw;
    logic       u_a0;
    logic [7:0] u_din;
    logic [7:0] u_dout;
    logic       req0_valid;
    logic       req1_valid;
    logic [7:0] req0_data;
    logic [7:0] req1_data;
    logic       req0_ready;
    logic       req1_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       grant;

    modport master (
        output u_cs, u_rnw, u_a0, u_din,
        input  u_dout,
        input  req0_valid, req1_valid, req0_data, req1_data,
        output req0_ready, req1_ready,
        output rx_valid, rx_data,
        input  rx_ready,
        output grant
    );

    modport slave (
        input  u_cs, u_rnw, u_a0, u_din,
        output u_dout,
        output req0_valid, req1_valid, req0_data, req1_data,
        input  req0_ready, req1_ready,
        input  rx_valid, rx_data,
        output rx_ready,
        input  grant
    );
endinterface

// File: rtl/uart_bus_ctrl.sv
// Polls a UART status register, drains RX bytes to a valid/ready consumer and round-robins two TX requesters.
// One UART access per POLL; RX stalls in the UART while rx_valid is held, TX waits for tx_busy=0.
module uart_bus_ctrl #(
    parameter bit RX_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    uart_bus_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, POLL, RXRD, TXWR} state_t;

    state_t     state;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       grant_q;
    logic       rxok;
    logic       txok;

    always_comb begin
        rxok = bus.u_dout[0] && !rx_valid_q;
        txok = !bus.u_dout[1] && (bus.req0_valid || bus.req1_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            grant_q    <= 1'b1;
        end else begin
            if (rx_valid_q && bus.rx_ready)
                rx_valid_q <= 1'b0;
            case (state)
                IDLE: state <= POLL;
                POLL: begin
                    if (rxok && (RX_FIRST || !txok)) begin
                        state <= RXRD;
                    end else if (txok) begin
                        state <= TXWR;
                        // Contention alternates away from the last winner.
                        if (bus.req0_valid && bus.req1_valid)
                            grant_q <= ~grant_q;
                        else
                            grant_q <= bus.req1_valid;
                    end
                end
                RXRD: begin
                    rx_data_q  <= bus.u_dout;
                    rx_valid_q <= 1'b1;
                    state      <= POLL;
                end
                TXWR:    state <= POLL;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset masks the decode so an access in flight is abandoned immediately.
    always_comb begin
        bus.u_cs       = 1'b0;
        bus.u_rnw      = 1'b1;
        bus.u_a0       = 1'b0;
        bus.u_din      = 8'h00;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (!reset) begin
            case (state)
                POLL: bus.u_cs = 1'b1;
                RXRD: begin
                    bus.u_cs = 1'b1;
                    bus.u_a0 = 1'b1;
                end
                TXWR: begin
                    bus.u_cs       = 1'b1;
                    bus.u_rnw      = 1'b0;
                    bus.u_a0       = 1'b1;
                    bus.u_din      = grant_q ? bus.req1_data : bus.req0_data;
                    bus.req0_ready = !grant_q;
                    bus.req1_ready = grant_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.grant    = grant_q;

endmodule

// File: doc/uart_bus_ctrl.md
UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

Interface
REQ-001 SHALL have parameter RX_FIRST, default 1; when 1, an RX drain wins over a TX write if both are possible in the same POLL cycle, and when 0, TX wins.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port u_cs, output, 1 bit: UART register select.
REQ-005 SHALL have port u_rnw, output, 1 bit: UART access direction; 1 = read, 0 = write.
REQ-006 SHALL have port u_a0, output, 1 bit: UART register address; 0 = status, 1 = data.
REQ-007 SHALL have port u_din, output, 8 bits: byte written to the UART data register.
REQ-008 SHALL have port u_dout, input, 8 bits: UART read data; in status reads, bit0 = rx_full and bit1 = tx_busy.
REQ-009 SHALL have ports req0_valid/req1_valid, input, 1 bit each: TX byte offered by requester 0/1.
REQ-010 SHALL have ports req0_data/req1_data, input, 8 bits each: TX byte of requester 0/1.
REQ-011 SHALL have ports req0_ready/req1_ready, output, 1 bit each: byte accepted, single-cycle pulse.
REQ-012 SHALL have port rx_valid, output, 1 bit: received byte held in rx_data.
REQ-013 SHALL have port rx_data, output, 8 bits: received byte.
REQ-014 SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data.
REQ-015 SHALL have port grant, output, 1 bit: index of the requester served by the last TX write.

Function
REQ-016 SHALL implement the states IDLE, POLL, RXRD and TXWR, with u_cs, u_rnw, u_a0 and u_din decoded combinationally from state and grant.
REQ-017 In IDLE, SHALL drive u_cs=0 and go to POLL next cycle.
REQ-018 In POLL, SHALL drive u_cs=1, u_rnw=1, u_a0=0 and choose the next state from the live u_dout.
  - rxok = u_dout[0] && !rx_valid
  - txok = !u_dout[1] && (req0_valid || req1_valid)
  - Next state: RXRD if rxok and (RX_FIRST or !txok); else TXWR if txok; else POLL.
REQ-019 In RXRD, SHALL drive u_cs=1, u_rnw=1, u_a0=1 for exactly one cycle, load rx_data from u_dout and set rx_valid at the closing edge, then go to POLL.
REQ-020 On the POLL->TXWR edge, SHALL register the arbitration result into grant.
  - Only one requester valid: that requester.
  - Both valid: the requester other than the current grant (round-robin).
REQ-021 In TXWR, SHALL drive u_cs=1, u_rnw=0, u_a0=1, u_din=data of the granted requester, assert that requester's ready for that one cycle only, then go to POLL.
REQ-022 Requesters SHALL hold valid and data stable until ready; deasserting valid while in TXWR still consumes the byte.
REQ-023 SHALL keep u_cs asserted for exactly one cycle per RXRD or TXWR access, with no back-to-back data accesses without an intervening POLL.
REQ-024 SHALL clear rx_valid on a clock edge where rx_valid && rx_ready.
REQ-025 While rx_valid=1, SHALL NOT enter RXRD; the UART holds the byte, so backpressure loses no data beyond the UART's own single-byte buffer.
REQ-026 The other ready output and u_din SHALL be 0 whenever not in TXWR for that requester.

Reset
REQ-027 On reset, SHALL set: state=IDLE, rx_valid=0, rx_data=8'h00, grant=1 (so requester 0 wins first contention), u_cs=0, u_rnw=1, u_a0=0, u_din=8'h00, req0_ready=0, req1_ready=0.
REQ-028 Reset asserted in RXRD or TXWR SHALL abort the access with no ready pulse and no rx_valid set; the first POLL occurs two cycles after reset deasserts.

Verification
REQ-029 The bench SHALL cover an idle UART with no requests: a repeating POLL cycle with u_cs=1, u_a0=0, u_rnw=1 each cycle, and both ready outputs 0.
REQ-030 The bench SHALL cover req0_valid=1, req0_data=8'hA5 with status 8'h00: one TXWR cycle with u_din=8'hA5, u_rnw=0, u_a0=1, req0_ready pulsed once, and grant=0.
REQ-031 The bench SHALL cover both requesters valid for 4 writes with status 8'h00: grants 0,1,0,1, each TXWR separated by a POLL.
REQ-032 The bench SHALL cover status 8'h01, data 8'h3C, RX_FIRST=1, with req0 also valid: RXRD first, then rx_valid=1 and rx_data=8'h3C; TXWR follows only after the next POLL.
REQ-033 The bench SHALL cover rx_valid=1, rx_ready=0 with status 8'h01: no RXRD entered; after rx_ready is pulsed, rx_valid=0 and the next POLL enters RXRD.
REQ-034 The bench SHALL cover reset asserted during TXWR: u_cs=0 and req0_ready=0 on the following cycle, then IDLE, then POLL.
